bp_lite_io_cmd_arbiter: RTL and testbench
=========================================

Name: bp_lite_io_cmd_arbiter

Overview:
- Shares one BedRock-lite io_cmd/io_resp port pair between num_clients_p BedRock-lite masters, e.g. several AXI-lite client bridges feeding a single I/O path.
- Commands are granted round-robin.
- A tag FIFO records the granting client of each accepted command, so in-order responses are routed back to the correct client.
- Up to max_outstanding_p commands may be in flight.

Parameters:
- bp_params_p, e_bp_default_cfg: processor config; sets cce_mem_msg_width_lp (msg width, W below).
- num_clients_p, 2: number of requesting masters; must be at least 2.
- max_outstanding_p, 4: tag FIFO depth, i.e. maximum accepted-but-unanswered commands; must be at least 1.
- Derived: lg_clients = max(1, $clog2(num_clients_p)).

Ports:
- clk_i, in, 1: clock.
- reset_i, in, 1: synchronous, active-high reset.
- client_cmd_i, in, num_clients_p*W: per-client command message; client k occupies bits [k*W +: W].
- client_cmd_v_i, in, num_clients_p: per-client command valid.
- client_cmd_yumi_o, out, num_clients_p: per-client command accept; one-hot or zero.
- client_resp_o, out, W: response message, broadcast to all clients.
- client_resp_v_o, out, num_clients_p: per-client response valid; one-hot or zero.
- client_resp_ready_i, in, num_clients_p: per-client response ready.
- io_cmd_o, out, W: arbitrated command.
- io_cmd_v_o, out, 1: arbitrated command valid.
- io_cmd_yumi_i, in, 1: downstream accept.
- io_resp_i, in, W: downstream response.
- io_resp_v_i, in, 1: response valid.
- io_resp_ready_o, out, 1: response ready.
- idle_o, out, 1: high when the tag FIFO is empty and no command is pending.

Behaviour:
Clock, reset and handshakes:
- One clock domain. Reset is synchronous and active-high.
- Reset clears the tag FIFO, the grant lock, and sets the round-robin pointer so client 0 has top priority.
- During reset and the first cycle after it, all valid/yumi/ready outputs are 0 and idle_o=1.
- Downstream command handshake is valid/yumi: a transfer occurs when io_cmd_v_o & io_cmd_yumi_i.
- Response handshake is valid/ready: a transfer occurs when io_resp_v_i & io_resp_ready_o.

Arbitration:
- Candidates are clients with client_cmd_v_i=1.
- When unlocked, the winner is the first valid client at or after the pointer, wrapping modulo num_clients_p.
- io_cmd_v_o = (any candidate | lock) & ~fifo_full.
- io_cmd_o = client_cmd_i slice of the selected client, zero-latency combinational mux.
- Lock: if io_cmd_v_o=1 and io_cmd_yumi_i=0, the selected index is registered. The grant stays on that client until yumi, even if a higher-priority client becomes valid. Clients must hold valid and data until yumi.
- On yumi:
  - client_cmd_yumi_o[sel]=1 that same cycle;
  - sel is pushed into the tag FIFO;
  - pointer <- (sel+1) mod num_clients_p;
  - lock clears.
- Full case: when fifo_full, io_cmd_v_o=0 even if a pop happens in the same cycle. There is no combinational full->empty path; the push waits one cycle.

Response routing:
- head = tag FIFO head.
- client_resp_o = io_resp_i, always passed through.
- client_resp_v_o[head] = io_resp_v_i & ~fifo_empty; all other bits are 0.
- io_resp_ready_o = client_resp_ready_i[head] & ~fifo_empty.
- Pop on the response handshake.
- Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
- io_resp_v_i while the FIFO is empty is a protocol error: io_resp_ready_o=0 and the sim-only $error fires.
- Responses are assumed in order, with one response per command and single-beat messages only.

Counter and FIFO:
- Occupancy counter width is $clog2(max_outstanding_p+1).
- fifo_full when count == max_outstanding_p; fifo_empty when count == 0.
- Read and write pointers wrap modulo max_outstanding_p; non-power-of-two depths must wrap correctly.

Idle and assertions:
- idle_o = fifo_empty & ~(any client_cmd_v_i) & ~lock.
- Elaboration: $fatal if num_clients_p<2 or max_outstanding_p<1.

Reset mid-operation:
- Outstanding tags are discarded.
- The downstream is assumed reset together with this block.
- Responses arriving after reset with an empty FIFO fall under the protocol-error rule.

Test Plan:
- Basic routing (num_clients_p=2): client 1 sends uc_rd to addr 0x0010_0000 with yumi the same cycle -> io_cmd_o equals client 1's msg and client_cmd_yumi_o=2'b10. A response arriving 3 cycles later -> client_resp_v_o=2'b10 and idle_o returns to 1.
- Round-robin fairness: both clients valid continuously, yumi every cycle, responses ready -> grant order 0,1,0,1,... Neither client is granted twice in a row.
- Grant lock: client 1 granted, yumi held 0 for 5 cycles while client 0 asserts valid at cycle 2 -> io_cmd_o stays client 1's msg. Client 0 is granted on the cycle after client 1's yumi.
- Full FIFO (max_outstanding_p=4): 4 commands accepted with no responses -> io_cmd_v_o=0 while client 0 is still valid. Response popped at cycle t -> io_cmd_v_o=1 at t+1, not at t.
- In-order routing with backpressure: grants 0,1,0 are accepted; the response for client 0 is held with client_resp_ready_i[0]=0 for 2 cycles -> io_resp_ready_o=0 during those cycles. The responses are then delivered to clients 0, 1, 0 in that order with no loss.
- Reset mid-operation: 2 commands outstanding, then reset_i pulsed for 1 cycle -> idle_o=1 and the pointer is at 0. The next simultaneous requests from clients 0 and 1 grant client 0 first.

Source files
------------

// File: rtl/bp_lite_io_cmd_arbiter.sv
// Round-robin arbiter sharing one BedRock-lite io_cmd/io_resp port pair among several masters.
// A tag FIFO remembers the granted client of every accepted command so in-order responses route back.
module bp_lite_io_cmd_arbiter #(
  parameter int cce_mem_msg_width_lp = 128,
  parameter int num_clients_p        = 2,
  parameter int max_outstanding_p    = 4
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,

  input  logic [num_clients_p*cce_mem_msg_width_lp-1:0] client_cmd_i,
  input  logic [num_clients_p-1:0]                      client_cmd_v_i,
  output logic [num_clients_p-1:0]                      client_cmd_yumi_o,

  output logic [cce_mem_msg_width_lp-1:0]               client_resp_o,
  output logic [num_clients_p-1:0]                      client_resp_v_o,
  input  logic [num_clients_p-1:0]                      client_resp_ready_i,

  output logic [cce_mem_msg_width_lp-1:0]               io_cmd_o,
  output logic                                          io_cmd_v_o,
  input  logic                                          io_cmd_yumi_i,

  input  logic [cce_mem_msg_width_lp-1:0]               io_resp_i,
  input  logic                                          io_resp_v_i,
  output logic                                          io_resp_ready_o,

  output logic                                          idle_o
);

  localparam int W          = cce_mem_msg_width_lp;
  localparam int lg_clients = (num_clients_p > 2) ? $clog2(num_clients_p) : 1;
  localparam int ptr_w_lp   = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w_lp   = $clog2(max_outstanding_p + 1);

  if (num_clients_p < 2 || max_outstanding_p < 1) begin : g_bad_params
    $fatal(1, "bp_lite_io_cmd_arbiter: num_clients_p must be >= 2 and max_outstanding_p >= 1");
  end

  logic                  en_q;
  logic                  lock_q, lock_d;
  logic [lg_clients-1:0] lock_idx_q, lock_idx_d;
  logic [lg_clients-1:0] rr_ptr_q, rr_ptr_d;
  logic [ptr_w_lp-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0]   count_q, count_d;
  logic [lg_clients-1:0] tag_mem_q [max_outstanding_p];

  logic                  active;
  logic                  any_v;
  logic                  fifo_full, fifo_empty;
  logic [lg_clients-1:0] rr_idx, sel, head;
  logic                  cmd_fire, resp_fire, head_ready;

  // Outputs stay quiet during reset and for the first cycle after it.
  assign active     = en_q & ~reset_i;
  assign any_v      = |client_cmd_v_i;
  assign fifo_full  = (count_q == cnt_w_lp'(max_outstanding_p));
  assign fifo_empty = (count_q == '0);
  assign head       = tag_mem_q[rptr_q];

  // First valid client at or after the round-robin pointer.
  always_comb begin
    int  idx;
    logic found;
    rr_idx = rr_ptr_q;
    found  = 1'b0;
    for (int i = 0; i < num_clients_p; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= num_clients_p) idx = idx - num_clients_p;
      if (!found && client_cmd_v_i[idx]) begin
        found  = 1'b1;
        rr_idx = lg_clients'(idx);
      end
    end
  end

  assign sel        = lock_q ? lock_idx_q : rr_idx;
  assign io_cmd_v_o = active & (any_v | lock_q) & ~fifo_full;
  assign cmd_fire   = io_cmd_v_o & io_cmd_yumi_i;

  always_comb begin
    io_cmd_o          = '0;
    client_cmd_yumi_o = '0;
    client_resp_v_o   = '0;
    head_ready        = 1'b0;
    for (int k = 0; k < num_clients_p; k++) begin
      if (sel == lg_clients'(k)) begin
        io_cmd_o             = client_cmd_i[k*W +: W];
        client_cmd_yumi_o[k] = cmd_fire;
      end
      if (head == lg_clients'(k)) begin
        head_ready         = client_resp_ready_i[k];
        client_resp_v_o[k] = active & io_resp_v_i & ~fifo_empty;
      end
    end
  end

  assign client_resp_o   = io_resp_i;
  assign io_resp_ready_o = active & head_ready & ~fifo_empty;
  assign resp_fire       = io_resp_v_i & io_resp_ready_o;
  assign idle_o          = ~active | (fifo_empty & ~any_v & ~lock_q);

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (cmd_fire) begin
      lock_d   = 1'b0;
      rr_ptr_d = (sel == lg_clients'(num_clients_p - 1)) ? '0 : sel + 1'b1;
      wptr_d   = (wptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : wptr_q + 1'b1;
    end else if (io_cmd_v_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
    if (resp_fire) begin
      rptr_d = (rptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : rptr_q + 1'b1;
    end
    case ({cmd_fire, resp_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      en_q       <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      en_q       <= 1'b1;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_fire) tag_mem_q[wptr_q] <= sel;
  end

  // A response with nothing outstanding means the downstream broke ordering.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(io_resp_v_i && fifo_empty))
        else $error("bp_lite_io_cmd_arbiter: io_resp_v_i with no outstanding command");
    end
  end

endmodule

// File: tb/tb_bp_lite_io_cmd_arbiter.sv
// Directed bench for bp_lite_io_cmd_arbiter: 2 clients, 4-deep tag FIFO, 64-bit messages.
module tb_bp_lite_io_cmd_arbiter;

  localparam int W = 64;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] client_cmd_i;
  logic [N-1:0]   client_cmd_v_i;
  logic [N-1:0]   client_cmd_yumi_o;
  logic [W-1:0]   client_resp_o;
  logic [N-1:0]   client_resp_v_o;
  logic [N-1:0]   client_resp_ready_i;
  logic [W-1:0]   io_cmd_o;
  logic           io_cmd_v_o;
  logic           io_cmd_yumi_i;
  logic [W-1:0]   io_resp_i;
  logic           io_resp_v_i;
  logic           io_resp_ready_o;
  logic           idle_o;

  int checks = 0;
  int errors = 0;

  localparam logic [W-1:0] MSG0 = 64'h0000_00A0_0000_1000;
  localparam logic [W-1:0] MSG1 = 64'h0000_0001_0010_0000;  // uc_rd to 0x0010_0000
  localparam logic [W-1:0] RSP  = 64'hDEAD_BEEF_0000_0001;

  always #5 clk = ~clk;

  bp_lite_io_cmd_arbiter #(
    .cce_mem_msg_width_lp(W),
    .num_clients_p(N),
    .max_outstanding_p(4)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .client_cmd_i(client_cmd_i),
    .client_cmd_v_i(client_cmd_v_i),
    .client_cmd_yumi_o(client_cmd_yumi_o),
    .client_resp_o(client_resp_o),
    .client_resp_v_o(client_resp_v_o),
    .client_resp_ready_i(client_resp_ready_i),
    .io_cmd_o(io_cmd_o),
    .io_cmd_v_o(io_cmd_v_o),
    .io_cmd_yumi_i(io_cmd_yumi_i),
    .io_resp_i(io_resp_i),
    .io_resp_v_i(io_resp_v_i),
    .io_resp_ready_o(io_resp_ready_o),
    .idle_o(idle_o)
  );

  always @(posedge clk) begin
    if (!reset_i && io_cmd_v_o && io_cmd_yumi_i)
      $display("cmd accepted: yumi=%b data=%h", client_cmd_yumi_o, io_cmd_o);
    if (!reset_i && io_resp_v_i && io_resp_ready_o)
      $display("resp delivered: resp_v=%b data=%h", client_resp_v_o, client_resp_o);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance one cycle, apply inputs just after the falling edge, let combinational outputs settle.
  task automatic drive(input logic [N-1:0] v, input logic y, input logic rv, input logic [N-1:0] rr);
    @(negedge clk);
    client_cmd_v_i      = v;
    io_cmd_yumi_i       = y;
    io_resp_v_i         = rv;
    client_resp_ready_i = rr;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset_i             = 1'b1;
    client_cmd_i        = {MSG1, MSG0};
    client_cmd_v_i      = 2'b11;
    io_cmd_yumi_i       = 1'b0;
    io_resp_i           = RSP;
    io_resp_v_i         = 1'b0;
    client_resp_ready_i = 2'b11;

    // Reset and the cycle after it: outputs quiet even with requests pending
    @(negedge clk); #1;
    chk("rst_cmd_v", W'(io_cmd_v_o), W'(1'b0));
    chk("rst_idle", W'(idle_o), W'(1'b1));
    chk("rst_resp_ready", W'(io_resp_ready_o), W'(1'b0));
    @(negedge clk);
    reset_i = 1'b0;
    io_cmd_yumi_i = 1'b1;
    #1;
    chk("post_rst_cmd_v", W'(io_cmd_v_o), W'(1'b0));
    chk("post_rst_yumi", W'(client_cmd_yumi_o), W'(2'b00));
    chk("post_rst_idle", W'(idle_o), W'(1'b1));
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    chk("quiet_idle", W'(idle_o), W'(1'b1));

    // Basic routing: client 1 alone
    drive(2'b10, 1'b1, 1'b0, 2'b11);
    chk("basic_cmd_v", W'(io_cmd_v_o), W'(1'b1));
    chk("basic_cmd", io_cmd_o, MSG1);
    chk("basic_yumi", W'(client_cmd_yumi_o), W'(2'b10));
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    chk("basic_busy", W'(idle_o), W'(1'b0));
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("basic_resp_v", W'(client_resp_v_o), W'(2'b10));
    chk("basic_resp", client_resp_o, RSP);
    chk("basic_resp_ready", W'(io_resp_ready_o), W'(1'b1));
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    chk("basic_idle", W'(idle_o), W'(1'b1));

    // Round-robin with simultaneous push/pop
    drive(2'b11, 1'b1, 1'b0, 2'b11);
    chk("rr_g0", W'(client_cmd_yumi_o), W'(2'b01));
    drive(2'b11, 1'b1, 1'b1, 2'b11);
    chk("rr_g1", W'(client_cmd_yumi_o), W'(2'b10));
    chk("rr_r0", W'(client_resp_v_o), W'(2'b01));
    drive(2'b11, 1'b1, 1'b1, 2'b11);
    chk("rr_g2", W'(client_cmd_yumi_o), W'(2'b01));
    chk("rr_r1", W'(client_resp_v_o), W'(2'b10));
    drive(2'b11, 1'b1, 1'b1, 2'b11);
    chk("rr_g3", W'(client_cmd_yumi_o), W'(2'b10));
    chk("rr_r2", W'(client_resp_v_o), W'(2'b01));
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("rr_r3", W'(client_resp_v_o), W'(2'b10));
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    chk("rr_idle", W'(idle_o), W'(1'b1));

    // Grant lock: client 1 waits 5 cycles, client 0 joins at cycle 2
    drive(2'b10, 1'b0, 1'b0, 2'b11);
    chk("lock_cmd0", io_cmd_o, MSG1);
    chk("lock_yumi0", W'(client_cmd_yumi_o), W'(2'b00));
    for (int c = 1; c < 5; c++) begin
      drive(2'b11, 1'b0, 1'b0, 2'b11);
      chk($sformatf("lock_cmd%0d", c), io_cmd_o, MSG1);
      chk($sformatf("lock_v%0d", c), W'(io_cmd_v_o), W'(1'b1));
    end
    drive(2'b11, 1'b1, 1'b0, 2'b11);
    chk("lock_release", W'(client_cmd_yumi_o), W'(2'b10));
    drive(2'b01, 1'b1, 1'b0, 2'b11);
    chk("lock_next", W'(client_cmd_yumi_o), W'(2'b01));
    chk("lock_next_cmd", io_cmd_o, MSG0);
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("lock_r1", W'(client_resp_v_o), W'(2'b10));
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("lock_r0", W'(client_resp_v_o), W'(2'b01));

    // Full FIFO: four accepts, then stall; pop frees a slot only a cycle later
    for (int c = 0; c < 4; c++) begin
      drive(2'b01, 1'b1, 1'b0, 2'b11);
      chk($sformatf("full_fill%0d", c), W'(client_cmd_yumi_o), W'(2'b01));
    end
    drive(2'b01, 1'b1, 1'b0, 2'b11);
    chk("full_v", W'(io_cmd_v_o), W'(1'b0));
    chk("full_yumi", W'(client_cmd_yumi_o), W'(2'b00));
    drive(2'b01, 1'b1, 1'b1, 2'b11);
    chk("full_pop_cycle_v", W'(io_cmd_v_o), W'(1'b0));
    chk("full_pop_resp", W'(client_resp_v_o), W'(2'b01));
    drive(2'b01, 1'b1, 1'b0, 2'b11);
    chk("full_after_pop_v", W'(io_cmd_v_o), W'(1'b1));
    chk("full_after_pop_yumi", W'(client_cmd_yumi_o), W'(2'b01));
    for (int c = 0; c < 4; c++) begin
      drive(2'b00, 1'b0, 1'b1, 2'b11);
      chk($sformatf("full_drain%0d", c), W'(client_resp_v_o), W'(2'b01));
    end
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    chk("full_idle", W'(idle_o), W'(1'b1));

    // In-order routing with client 0 backpressure
    drive(2'b01, 1'b1, 1'b0, 2'b11);
    chk("bp_g0", W'(client_cmd_yumi_o), W'(2'b01));
    drive(2'b11, 1'b1, 1'b0, 2'b11);
    chk("bp_g1", W'(client_cmd_yumi_o), W'(2'b10));
    drive(2'b11, 1'b1, 1'b0, 2'b11);
    chk("bp_g2", W'(client_cmd_yumi_o), W'(2'b01));
    for (int c = 0; c < 2; c++) begin
      drive(2'b00, 1'b0, 1'b1, 2'b10);
      chk($sformatf("bp_hold_ready%0d", c), W'(io_resp_ready_o), W'(1'b0));
      chk($sformatf("bp_hold_v%0d", c), W'(client_resp_v_o), W'(2'b01));
    end
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("bp_r0_ready", W'(io_resp_ready_o), W'(1'b1));
    chk("bp_r0", W'(client_resp_v_o), W'(2'b01));
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("bp_r1", W'(client_resp_v_o), W'(2'b10));
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("bp_r2", W'(client_resp_v_o), W'(2'b01));
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    chk("bp_idle", W'(idle_o), W'(1'b1));

    // Reset with two commands outstanding and the pointer at client 1
    drive(2'b10, 1'b1, 1'b0, 2'b11);
    chk("mr_g1", W'(client_cmd_yumi_o), W'(2'b10));
    drive(2'b01, 1'b1, 1'b0, 2'b11);
    chk("mr_g0", W'(client_cmd_yumi_o), W'(2'b01));
    @(negedge clk);
    reset_i = 1'b1;
    client_cmd_v_i = 2'b11;
    io_cmd_yumi_i = 1'b0;
    #1;
    chk("mr_rst_v", W'(io_cmd_v_o), W'(1'b0));
    chk("mr_rst_idle", W'(idle_o), W'(1'b1));
    @(negedge clk);
    reset_i = 1'b0;
    io_cmd_yumi_i = 1'b1;
    #1;
    chk("mr_post_v", W'(io_cmd_v_o), W'(1'b0));
    drive(2'b11, 1'b1, 1'b0, 2'b11);
    chk("mr_resp_ready", W'(io_resp_ready_o), W'(1'b0));
    chk("mr_first", W'(client_cmd_yumi_o), W'(2'b01));
    drive(2'b11, 1'b1, 1'b0, 2'b11);
    chk("mr_second", W'(client_cmd_yumi_o), W'(2'b10));
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("mr_r0", W'(client_resp_v_o), W'(2'b01));
    drive(2'b00, 1'b0, 1'b1, 2'b11);
    chk("mr_r1", W'(client_resp_v_o), W'(2'b10));
    drive(2'b00, 1'b0, 1'b0, 2'b11);
    chk("mr_idle", W'(idle_o), W'(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
